// File: rtl/quote_generator.sv
// Turns Q32.32 reference prices into floor/ceil-rounded, clamped integer bid/ask quotes with
// latest-wins buffering and a minimum inter-quote gap. Define QUOTE_SUPPRESS_EN to drop repeat quotes.
module quote_generator #(
    parameter int FP_WORD_SIZE   = 64,
    parameter int DATA_WIDTH     = 32,
    parameter int MIN_GAP_CYCLES = 4,
    parameter int DROP_CNT_WIDTH = 16
) (
    input  logic                      i_clk,
    input  logic                      i_reset_n,
    input  logic [FP_WORD_SIZE-1:0]   i_ref_price,
    input  logic                      i_ref_valid,
    input  logic [FP_WORD_SIZE-1:0]   i_half_spread,
    output logic [DATA_WIDTH-1:0]     o_bid_price,
    output logic [DATA_WIDTH-1:0]     o_ask_price,
    output logic                      o_quote_valid,
    input  logic                      i_quote_ready,
    output logic                      o_busy,
    output logic [DROP_CNT_WIDTH-1:0] o_drop_cnt
);

    localparam int FRAC_W = FP_WORD_SIZE / 2;
    localparam int EXT_W  = FP_WORD_SIZE + 2;
    localparam int INT_W  = EXT_W - FRAC_W;
    localparam int GAP_W  = (MIN_GAP_CYCLES > 0) ? $clog2(MIN_GAP_CYCLES + 1) : 1;
    localparam logic [GAP_W-1:0]      GAP_MAX = GAP_W'(MIN_GAP_CYCLES);
    localparam logic [DATA_WIDTH-1:0] Q_MAX   = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC1,
        S_CALC2,
        S_WAIT_GAP,
        S_OFFER
    } state_t;

    state_t                    state_q, state_d;
    logic [FP_WORD_SIZE-1:0]   ref_q, ref_d, hs_q, hs_d;
    logic [EXT_W-1:0]          lo_q, lo_d, hi_q, hi_d;
    logic [DATA_WIDTH-1:0]     bid_q, bid_d, ask_q, ask_d;
    logic                      pend_valid_q, pend_valid_d;
    logic [FP_WORD_SIZE-1:0]   pend_ref_q, pend_ref_d, pend_hs_q, pend_hs_d;
    logic [DROP_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
    logic [GAP_W-1:0]          gap_cnt_q, gap_cnt_d;
`ifdef QUOTE_SUPPRESS_EN
    logic [DATA_WIDTH-1:0]     last_bid_q, last_bid_d, last_ask_q, last_ask_d;
    logic                      have_last_q, have_last_d;
`endif

    logic [EXT_W-1:0]          ext_ref, ext_hs;
    logic [INT_W-1:0]          lo_int, hi_ceil;
    logic [DATA_WIDTH-1:0]     bid_clamp, ask_clamp, bid_new, ask_new;
    logic                      lo_frac_unused;

    // Sign-extended price, zero-extended half-spread: 66 bits cannot overflow.
    assign ext_ref        = {{2{ref_q[FP_WORD_SIZE-1]}}, ref_q};
    assign ext_hs         = {2'b00, hs_q};
    assign lo_frac_unused = ^lo_q[FRAC_W-1:0];

    function automatic logic [DATA_WIDTH-1:0] clamp_int(input logic [INT_W-1:0] v);
        if (v[INT_W-1]) begin
            return '0;
        end else if (|v[INT_W-2:DATA_WIDTH]) begin
            return Q_MAX;
        end else begin
            return v[DATA_WIDTH-1:0];
        end
    endfunction

    always_comb begin
        lo_int    = lo_q[EXT_W-1:FRAC_W];
        hi_ceil   = hi_q[EXT_W-1:FRAC_W] + INT_W'(|hi_q[FRAC_W-1:0]);
        bid_clamp = clamp_int(lo_int);
        ask_clamp = clamp_int(hi_ceil);
        bid_new   = bid_clamp;
        ask_new   = ask_clamp;
        if (ask_clamp <= bid_clamp) begin
            if (bid_clamp == Q_MAX) begin
                bid_new = Q_MAX - DATA_WIDTH'(1);
                ask_new = Q_MAX;
            end else begin
                ask_new = bid_clamp + DATA_WIDTH'(1);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        ref_d        = ref_q;
        hs_d         = hs_q;
        lo_d         = lo_q;
        hi_d         = hi_q;
        bid_d        = bid_q;
        ask_d        = ask_q;
        pend_valid_d = pend_valid_q;
        pend_ref_d   = pend_ref_q;
        pend_hs_d    = pend_hs_q;
        drop_cnt_d   = drop_cnt_q;
        gap_cnt_d    = (gap_cnt_q >= GAP_MAX) ? GAP_MAX : gap_cnt_q + GAP_W'(1);
`ifdef QUOTE_SUPPRESS_EN
        last_bid_d   = last_bid_q;
        last_ask_d   = last_ask_q;
        have_last_d  = have_last_q;
`endif

        // Updates arriving mid-quote park in the pending slot; overwriting a full slot is a drop.
        if (state_q != S_IDLE && i_ref_valid) begin
            pend_valid_d = 1'b1;
            pend_ref_d   = i_ref_price;
            pend_hs_d    = i_half_spread;
            if (pend_valid_q && drop_cnt_q != '1) begin
                drop_cnt_d = drop_cnt_q + DROP_CNT_WIDTH'(1);
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (pend_valid_q) begin
                    ref_d        = pend_ref_q;
                    hs_d         = pend_hs_q;
                    pend_valid_d = i_ref_valid;
                    if (i_ref_valid) begin
                        pend_ref_d = i_ref_price;
                        pend_hs_d  = i_half_spread;
                    end
                    state_d = S_CALC1;
                end else if (i_ref_valid) begin
                    ref_d   = i_ref_price;
                    hs_d    = i_half_spread;
                    state_d = S_CALC1;
                end
            end
            S_CALC1: begin
                lo_d    = ext_ref - ext_hs;
                hi_d    = ext_ref + ext_hs;
                state_d = S_CALC2;
            end
            S_CALC2: begin
                bid_d   = bid_new;
                ask_d   = ask_new;
                state_d = (gap_cnt_q >= GAP_MAX) ? S_OFFER : S_WAIT_GAP;
`ifdef QUOTE_SUPPRESS_EN
                if (have_last_q && bid_new == last_bid_q && ask_new == last_ask_q) begin
                    state_d = S_IDLE;
                end
`endif
            end
            S_WAIT_GAP: begin
                if (gap_cnt_q >= GAP_MAX) begin
                    state_d = S_OFFER;
                end
            end
            S_OFFER: begin
                if (i_quote_ready) begin
                    gap_cnt_d = '0;
`ifdef QUOTE_SUPPRESS_EN
                    last_bid_d  = bid_q;
                    last_ask_d  = ask_q;
                    have_last_d = 1'b1;
`endif
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q      <= S_IDLE;
            ref_q        <= '0;
            hs_q         <= '0;
            lo_q         <= '0;
            hi_q         <= '0;
            bid_q        <= '0;
            ask_q        <= '0;
            pend_valid_q <= 1'b0;
            pend_ref_q   <= '0;
            pend_hs_q    <= '0;
            drop_cnt_q   <= '0;
            gap_cnt_q    <= GAP_MAX;
`ifdef QUOTE_SUPPRESS_EN
            last_bid_q   <= '0;
            last_ask_q   <= '0;
            have_last_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            ref_q        <= ref_d;
            hs_q         <= hs_d;
            lo_q         <= lo_d;
            hi_q         <= hi_d;
            bid_q        <= bid_d;
            ask_q        <= ask_d;
            pend_valid_q <= pend_valid_d;
            pend_ref_q   <= pend_ref_d;
            pend_hs_q    <= pend_hs_d;
            drop_cnt_q   <= drop_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
`ifdef QUOTE_SUPPRESS_EN
            last_bid_q   <= last_bid_d;
            last_ask_q   <= last_ask_d;
            have_last_q  <= have_last_d;
`endif
        end
    end

    assign o_bid_price   = bid_q;
    assign o_ask_price   = ask_q;
    assign o_quote_valid = (state_q == S_OFFER);
    assign o_busy        = (state_q != S_IDLE);
    assign o_drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_quote_generator.sv
// Directed self-checking bench for quote_generator: rounding/clamping, latency, pending slot,
// throttle, optional suppression (QUOTE_SUPPRESS_EN) and mid-quote reset.
module tb_quote_generator;

    localparam int FPW = 64;
    localparam int DW  = 32;
    localparam int GAP = 4;
    localparam int DCW = 16;

    logic           i_clk = 1'b0;
    logic           i_reset_n = 1'b0;
    logic [FPW-1:0] i_ref_price = '0;
    logic           i_ref_valid = 1'b0;
    logic [FPW-1:0] i_half_spread = '0;
    logic [DW-1:0]  o_bid_price;
    logic [DW-1:0]  o_ask_price;
    logic           o_quote_valid;
    logic           i_quote_ready = 1'b0;
    logic           o_busy;
    logic [DCW-1:0] o_drop_cnt;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [FPW-1:0] ref_p;
        logic [FPW-1:0] hs;
        logic [DW-1:0]  bid;
        logic [DW-1:0]  ask;
    } vec_t;

    always #5 i_clk = ~i_clk;

    quote_generator #(
        .FP_WORD_SIZE  (FPW),
        .DATA_WIDTH    (DW),
        .MIN_GAP_CYCLES(GAP),
        .DROP_CNT_WIDTH(DCW)
    ) dut (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_ref_price  (i_ref_price),
        .i_ref_valid  (i_ref_valid),
        .i_half_spread(i_half_spread),
        .o_bid_price  (o_bid_price),
        .o_ask_price  (o_ask_price),
        .o_quote_valid(o_quote_valid),
        .i_quote_ready(i_quote_ready),
        .o_busy       (o_busy),
        .o_drop_cnt   (o_drop_cnt)
    );

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drive_ref(input logic [FPW-1:0] p, input logic [FPW-1:0] hs);
        i_ref_price   = p;
        i_half_spread = hs;
        i_ref_valid   = 1'b1;
        tick();
        i_ref_valid   = 1'b0;
    endtask

    task automatic wait_valid(input int limit, output int cycles, output bit seen);
        cycles = 0;
        seen   = o_quote_valid;
        while (!seen && cycles < limit) begin
            tick();
            cycles++;
            seen = o_quote_valid;
        end
    endtask

    task automatic test_reset();
        i_reset_n = 1'b0;
        idle(2);
        checks++;
        if (o_quote_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", o_quote_valid); end
        checks++;
        if (o_bid_price !== '0 || o_ask_price !== '0) begin
            errors++; $display("[TB] FAIL reset_quote: got %0d/%0d expected 0/0", o_bid_price, o_ask_price);
        end
        checks++;
        if (o_drop_cnt !== '0 || o_busy !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_state: drop %0d busy %b expected 0 0", o_drop_cnt, o_busy);
        end
        i_reset_n = 1'b1;
        idle(1);
    endtask

    task automatic test_basic();
        i_quote_ready = 1'b1;
        drive_ref(64'h00000064_80000000, 64'h00000000_40000000);
        checks++;
        if (o_quote_valid !== 1'b0 || o_busy !== 1'b1) begin
            errors++; $display("[TB] FAIL basic_n0: valid %b busy %b expected 0 1", o_quote_valid, o_busy);
        end
        tick();
        checks++;
        if (o_quote_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_n1: valid %b expected 0", o_quote_valid); end
        tick();
        checks++;
        if (o_quote_valid !== 1'b1 || o_bid_price !== 32'd100 || o_ask_price !== 32'd101) begin
            errors++; $display("[TB] FAIL basic_n2: valid %b quote %0d/%0d expected 1 100/101",
                               o_quote_valid, o_bid_price, o_ask_price);
        end
        tick();
        checks++;
        if (o_quote_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_one_cycle: valid %b expected 0", o_quote_valid); end
        idle(8);
    endtask

    task automatic test_rounding();
        vec_t vecs[6];
        int   cyc;
        bit   seen;
        vecs[0] = '{64'hFFFFFFFF_00000000, 64'h00000001_00000000, 32'd0, 32'd1};
        vecs[1] = '{64'h00000005_00000001, 64'h0, 32'd5, 32'd6};
        vecs[2] = '{64'hFFFFFFFF_40000000, 64'h0, 32'd0, 32'd1};
        vecs[3] = '{64'h7FFFFFFF_80000000, 64'h80000000_00000000, 32'd0, 32'hFFFFFFFF};
        vecs[4] = '{64'h00000064_00000000, 64'h0, 32'd100, 32'd101};
        vecs[5] = '{64'h000003E8_00000000, 64'h0000000A_80000000, 32'd989, 32'd1011};
        i_quote_ready = 1'b1;
        for (int v = 0; v < 6; v++) begin
            drive_ref(vecs[v].ref_p, vecs[v].hs);
            wait_valid(10, cyc, seen);
            checks++;
            if (!seen || o_bid_price !== vecs[v].bid || o_ask_price !== vecs[v].ask) begin
                errors++; $display("[TB] FAIL round_vec%0d: seen %b quote %0d/%0d expected 1 %0d/%0d",
                                   v, seen, o_bid_price, o_ask_price, vecs[v].bid, vecs[v].ask);
            end
            tick();
            idle(8);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        bit seen;
        i_quote_ready = 1'b1;
        i_half_spread = 64'h00000000_40000000;
        i_ref_price   = 64'h00000064_80000000;
        i_ref_valid   = 1'b1;
        tick();
        i_ref_price   = 64'h00000066_80000000;
        tick();
        i_ref_valid   = 1'b0;
        tick();
        checks++;
        if (o_quote_valid !== 1'b1 || o_bid_price !== 32'd100 || o_ask_price !== 32'd101) begin
            errors++; $display("[TB] FAIL b2b_first: valid %b quote %0d/%0d expected 1 100/101",
                               o_quote_valid, o_bid_price, o_ask_price);
        end
        tick();
        wait_valid(20, cyc, seen);
        checks++;
        if (!seen || cyc + 1 < GAP) begin
            errors++; $display("[TB] FAIL b2b_gap: seen %b gap %0d cycles expected at least %0d", seen, cyc + 1, GAP);
        end
        checks++;
        if (o_bid_price !== 32'd102 || o_ask_price !== 32'd103) begin
            errors++; $display("[TB] FAIL b2b_second: quote %0d/%0d expected 102/103", o_bid_price, o_ask_price);
        end
        tick();
        idle(8);
    endtask

    task automatic test_backpressure();
        int cyc;
        bit seen;
        i_quote_ready = 1'b0;
        drive_ref(64'h00000064_80000000, 64'h00000000_40000000);
        wait_valid(10, cyc, seen);
        checks++;
        if (!seen || o_bid_price !== 32'd100 || o_ask_price !== 32'd101) begin
            errors++; $display("[TB] FAIL bp_a_offer: seen %b quote %0d/%0d expected 1 100/101", seen, o_bid_price, o_ask_price);
        end
        drive_ref(64'h000000C8_00000000, 64'h0);
        drive_ref(64'h0000012C_00000000, 64'h0);
        drive_ref(64'h00000190_80000000, 64'h00000000_40000000);
        checks++;
        if (o_drop_cnt !== 16'd2) begin errors++; $display("[TB] FAIL bp_drop_cnt: got %0d expected 2", o_drop_cnt); end
        idle(3);
        checks++;
        if (o_quote_valid !== 1'b1 || o_bid_price !== 32'd100 || o_ask_price !== 32'd101) begin
            errors++; $display("[TB] FAIL bp_a_stable: valid %b quote %0d/%0d expected 1 100/101",
                               o_quote_valid, o_bid_price, o_ask_price);
        end
        i_quote_ready = 1'b1;
        tick();
        checks++;
        if (o_quote_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_a_accept: valid %b expected 0", o_quote_valid); end
        wait_valid(20, cyc, seen);
        checks++;
        if (!seen || o_bid_price !== 32'd400 || o_ask_price !== 32'd401) begin
            errors++; $display("[TB] FAIL bp_d_offer: seen %b quote %0d/%0d expected 1 400/401", seen, o_bid_price, o_ask_price);
        end
        tick();
        wait_valid(20, cyc, seen);
        checks++;
        if (seen) begin
            errors++; $display("[TB] FAIL bp_no_extra: extra quote %0d/%0d expected none", o_bid_price, o_ask_price);
            tick();
        end
        idle(4);
    endtask

    task automatic test_suppression();
        int cyc;
        bit seen;
        i_quote_ready = 1'b1;
        drive_ref(64'h00000032_00000000, 64'h00000002_00000000);
        wait_valid(10, cyc, seen);
        checks++;
        if (!seen || o_bid_price !== 32'd48 || o_ask_price !== 32'd52) begin
            errors++; $display("[TB] FAIL sup_first: seen %b quote %0d/%0d expected 1 48/52", seen, o_bid_price, o_ask_price);
        end
        tick();
        idle(8);
        drive_ref(64'h00000032_00000000, 64'h00000002_00000000);
        wait_valid(15, cyc, seen);
        checks++;
`ifdef QUOTE_SUPPRESS_EN
        if (seen) begin
            errors++; $display("[TB] FAIL sup_repeat: repeat quote offered %0d/%0d expected none", o_bid_price, o_ask_price);
        end
`else
        if (!seen || o_bid_price !== 32'd48 || o_ask_price !== 32'd52) begin
            errors++; $display("[TB] FAIL sup_repeat: seen %b quote %0d/%0d expected 1 48/52", seen, o_bid_price, o_ask_price);
        end
`endif
        if (seen) tick();
        idle(8);
    endtask

    task automatic test_reset_mid();
        int cyc;
        bit seen;
        bit busy_seen;
        i_quote_ready = 1'b0;
        drive_ref(64'h0000000A_00000000, 64'h0);
        wait_valid(10, cyc, seen);
        drive_ref(64'h00000014_00000000, 64'h0);
        drive_ref(64'h0000001E_00000000, 64'h0);
        checks++;
        if (!seen || o_drop_cnt !== 16'd3) begin
            errors++; $display("[TB] FAIL rst_pre: seen %b drop %0d expected 1 3", seen, o_drop_cnt);
        end
        i_reset_n = 1'b0;
        tick();
        i_reset_n = 1'b1;
        checks++;
        if (o_quote_valid !== 1'b0 || o_bid_price !== '0 || o_ask_price !== '0 || o_drop_cnt !== '0) begin
            errors++; $display("[TB] FAIL rst_mid_outputs: valid %b quote %0d/%0d drop %0d expected 0 0/0 0",
                               o_quote_valid, o_bid_price, o_ask_price, o_drop_cnt);
        end
        busy_seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            busy_seen |= o_busy;
            tick();
        end
        checks++;
        if (busy_seen) begin errors++; $display("[TB] FAIL rst_pending_cleared: busy 1 after reset expected 0"); end
        i_quote_ready = 1'b1;
        drive_ref(64'h00000014_80000000, 64'h00000000_40000000);
        tick();
        tick();
        tick();
        i_reset_n = 1'b0;
        tick();
        i_reset_n = 1'b1;
        drive_ref(64'h0000001E_80000000, 64'h00000000_40000000);
        tick();
        tick();
        checks++;
        if (o_quote_valid !== 1'b1 || o_bid_price !== 32'd30 || o_ask_price !== 32'd31) begin
            errors++; $display("[TB] FAIL rst_no_throttle: valid %b quote %0d/%0d expected 1 30/31",
                               o_quote_valid, o_bid_price, o_ask_price);
        end
        tick();
        idle(4);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_back_to_back();
        test_backpressure();
        test_suppression();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/quote_generator.md
Name: quote_generator

Overview:
- Downstream stage of the reference-price calculator. Consumes each Q32.32 reference price (one-cycle valid pulse, no backpressure) and produces integer bid/ask quotes as reference ∓ half-spread.
- Rounds bid down and ask up, saturates both, and enforces ask > bid.
- Presents quotes to the order-entry stage over a valid/ready handshake, with latest-wins buffering and a minimum inter-quote gap.

Parameters:
- FP_WORD_SIZE, 64: width of fixed-point inputs; format is signed two's-complement Q32.32.
- DATA_WIDTH, 32: width of integer quote outputs.
- MIN_GAP_CYCLES, 4: minimum number of cycles between accepted quotes; 0 disables throttling.
- DROP_CNT_WIDTH, 16: width of the dropped-update counter.

Ports:
- i_clk  in  1  clock
- i_reset_n  in  1  reset, synchronous, active-low
- i_ref_price  in  FP_WORD_SIZE  reference price, signed Q32.32
- i_ref_valid  in  1  one-cycle qualifier for i_ref_price
- i_half_spread  in  FP_WORD_SIZE  half-spread, unsigned Q32.32
- o_bid_price  out  DATA_WIDTH  bid, integer
- o_ask_price  out  DATA_WIDTH  ask, integer
- o_quote_valid  out  1  quote offered
- i_quote_ready  in  1  downstream accepts
- o_busy  out  1  FSM not in S_IDLE
- o_drop_cnt  out  DROP_CNT_WIDTH  count of pending updates overwritten; saturating

Behaviour:
- Reset: i_reset_n is synchronous, active-low, clocked by i_clk. All of the following reset to 0: outputs, pending flag, last-quote registers, have_last. gap_cnt resets to MIN_GAP_CYCLES, so the first quote is not throttled. FSM resets to S_IDLE. Reset mid-operation abandons any in-flight or offered quote.
- FSM transitions:
  - S_IDLE: on i_ref_valid, or pending flag set, capture price and i_half_spread into working registers → S_CALC1. A pending entry takes priority and clears the flag; a simultaneous i_ref_valid then becomes the new pending entry.
  - S_CALC1: compute lo = ref − hs and hi = ref + hs in 66-bit signed arithmetic → S_CALC2.
  - S_CALC2: apply rounding and clamping, register o_bid_price and o_ask_price.
    - With suppression enabled (see Optional Feature), a quote equal to the last accepted quote goes → S_IDLE.
    - Else if gap_cnt ≥ MIN_GAP_CYCLES → S_OFFER.
    - Else → S_WAIT_GAP.
  - S_WAIT_GAP: → S_OFFER when gap_cnt ≥ MIN_GAP_CYCLES.
  - S_OFFER: o_quote_valid = 1. Bid and ask stay stable until the handshake. When o_quote_valid && i_quote_ready: update the last-quote registers, set have_last, clear gap_cnt → S_IDLE.
- Arithmetic and width rules:
  - bid = floor(lo): integer part of lo. If lo < 0, bid = 0. If lo > 2^DATA_WIDTH − 1, bid = 2^DATA_WIDTH − 1.
  - ask = ceil(hi): integer part plus 1 if any fraction bit is set. Clamp the same way as bid.
  - If ask ≤ bid: ask = bid + 1. If bid is the maximum value, instead bid = max − 1 and ask = max.
- Latency: i_ref_valid sampled at edge N in S_IDLE, no throttle → o_quote_valid high after edge N+2.
- Pending slot:
  - i_ref_valid arriving while o_busy is high stores price and half-spread in the pending slot (latest wins).
  - If the slot is already full, o_drop_cnt increments, saturating at its maximum value.
- gap_cnt: increments every cycle, saturating at MIN_GAP_CYCLES.
- o_quote_valid never deasserts without a handshake, except on reset.

Optional Feature:
- Macro: QUOTE_SUPPRESS_EN.
- Defined: in S_CALC2, if have_last = 1 and both bid and ask equal the last accepted quote, no quote is offered and the FSM returns → S_IDLE. gap_cnt is unaffected.
- Undefined: every computed quote is offered, and the last-quote registers are not implemented.

Test Plan:
- Basic quote: ref 0x00000064_80000000 (100.5), hs 0x00000000_40000000 (0.25), ready = 1 → bid 100, ask 101. o_quote_valid high after edge N+2 and for exactly one cycle.
- Crossed-quote fix: ref 100.0, hs 0 → bid 100, ask 101. Negative clamp: ref 0xFFFFFFFF_00000000 (−1.0), hs 1.0 → bid 0, ask 1.
- Backpressure: hold ready = 0, offer quote A, then pulse refs B, C, D on separate cycles → drop_cnt = 2. After ready = 1, outputs are A, then D; B and C are never offered.
- Throttle: MIN_GAP_CYCLES = 4, ready = 1, refs 100.5 then 102.5 on back-to-back-eligible cycles → second o_quote_valid appears no earlier than 4 cycles after the first handshake.
- Suppression (QUOTE_SUPPRESS_EN defined): same ref twice → one quote. Undefined → two identical quotes.
- Reset: assert i_reset_n = 0 during S_OFFER → next cycle o_quote_valid = 0, bid, ask and drop_cnt = 0, pending flag cleared. A new ref afterwards is quoted with no throttle delay.
